// File: rtl/led_stretch_pwm.sv
// led_stretch_pwm: conditions the 8-bit LED export for the board LEDs.
// Each rising edge on a bit keeps that bit lit for at least STRETCH_CYCLES
// clocks, a global PWM gate scales brightness, and input changes are counted
// (saturating) for debug readback.
//
// Build option: define LED_STRETCH_EN to build the per-bit stretch counters.
// Without it the stretched vector is just the registered input; PWM and the
// change counter are identical in both builds.
//
// Single clock domain (Clk), synchronous active-high Reset.

module led_stretch_pwm #(
   parameter int WIDTH          = 8,
   parameter int STRETCH_CYCLES = 2500000,
   parameter int PWM_BITS       = 4
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [WIDTH-1:0]    led_in,
   input  logic [PWM_BITS-1:0] brightness,
   output logic [WIDTH-1:0]    led_out,
   output logic                activity,
   output logic [15:0]         change_count
);

   // A stretch of zero cycles would make the counter width degenerate.
   if (STRETCH_CYCLES < 1) begin : g_bad_cfg
      $error("led_stretch_pwm: STRETCH_CYCLES must be >= 1");
   end

   localparam logic [15:0] CC_MAX = 16'hFFFF;

   logic [WIDTH-1:0]    led_q,          led_d;
   logic [PWM_BITS-1:0] bri_q,          bri_d;
   logic [PWM_BITS-1:0] pwm_cnt_q,      pwm_cnt_d;
   logic [WIDTH-1:0]    led_out_q,      led_out_d;
   logic                activity_q,     activity_d;
   logic [15:0]         change_count_q, change_count_d;

   logic [WIDTH-1:0]    stretched;
   logic                gate;

`ifdef LED_STRETCH_EN
   localparam int              CNT_W    = $clog2(STRETCH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH_CYCLES);

   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

   // Per-bit stretch timers: reload on a rising edge (wins over decrement),
   // otherwise count down to zero; falling edges are ignored.
   always_comb begin
      cnt_d     = cnt_q;
      stretched = '0;
      for (int i = 0; i < WIDTH; i++) begin
         stretched[i] = led_q[i] | (cnt_q[i] != '0);
         if (led_in[i] & ~led_q[i]) begin
            cnt_d[i] = CNT_LOAD;
         end else if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
      end
   end

   // Stretch timer registers; reset aborts any stretch in progress.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   // No stretching: the registered input drives the LEDs directly.
   assign stretched = led_q;
`endif

   // Input capture, PWM phase, gated output and saturating change counter.
   always_comb begin
      led_d     = led_in;
      bri_d     = brightness;
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

      // All-ones brightness forces full on; otherwise duty = bri_q / 2^PWM_BITS.
      gate       = (bri_q == '1) | (pwm_cnt_q < bri_q);
      led_out_d  = stretched & {WIDTH{gate}};
      activity_d = |stretched;

      change_count_d = change_count_q;
      if ((led_in != led_q) && (change_count_q != CC_MAX)) begin
         change_count_d = change_count_q + 16'd1;
      end
   end

   // State registers; reset has priority over every update.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         led_q          <= '0;
         bri_q          <= '0;
         pwm_cnt_q      <= '0;
         led_out_q      <= '0;
         activity_q     <= 1'b0;
         change_count_q <= '0;
      end else begin
         led_q          <= led_d;
         bri_q          <= bri_d;
         pwm_cnt_q      <= pwm_cnt_d;
         led_out_q      <= led_out_d;
         activity_q     <= activity_d;
         change_count_q <= change_count_d;
      end
   end

   assign led_out      = led_out_q;
   assign activity     = activity_q;
   assign change_count = change_count_q;

endmodule
